// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and response codes.
package counter_pkg;

    // One-hot sequencer states
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_DRIVE = 5'b00010,
        ST_DRAIN = 5'b00100,
        ST_RESP  = 5'b01000,
        ST_FAULT = 5'b10000
    } state_t;

    // Response error codes returned on rsp_err
    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_RANGE    = 2'b01,
        ERR_MISMATCH = 2'b10,
        ERR_FAULT    = 2'b11
    } rsp_err_t;

    localparam int RSP_ERR_WIDTH = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index after the last granted one.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr;

    // Search forward from the slot after the last grant, wrapping around, first hit wins
    always_comb begin
        int   target;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        target    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            target = int'(ptr) + off;
            if (target >= NUM_REQ) begin
                target = target - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req[i] && (i == target)) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = IDX_W'(i);
                end
            end
        end
    end

    // Pointer remembers the last granted requester and moves only when a transfer happens
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Shares one up/down counter between several requesters: arbitrates, range-checks,
// steps the counter N times, verifies the result and returns a response.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 4,
    parameter int STEP_WIDTH    = 4,
    parameter int NUM_REQ       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_dir,
    input  logic [NUM_REQ*STEP_WIDTH-1:0] req_steps,
    output logic                          cnt_act,
    output logic                          cnt_updown,
    input  logic [COUNTER_WIDTH-1:0]      cnt_count,
    input  logic                          cnt_overflow,
    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [RSP_ERR_WIDTH-1:0]      rsp_err,
    output logic [COUNTER_WIDTH-1:0]      rsp_count,
    output logic                          fault
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SUM_W = ((COUNTER_WIDTH > STEP_WIDTH) ? COUNTER_WIDTH : STEP_WIDTH) + 1;
    localparam logic [SUM_W-1:0] MAX_COUNT = {{(SUM_W-COUNTER_WIDTH){1'b0}}, {COUNTER_WIDTH{1'b1}}};

    state_t                   state;
    state_t                   next_state;
    logic [NUM_REQ-1:0]       grant;
    logic [IDX_W-1:0]         grant_idx;
    logic                     transfer;
    logic                     sel_dir;
    logic [STEP_WIDTH-1:0]    sel_steps;
    logic [SUM_W-1:0]         up_sum;
    logic                     range_bad;
    logic                     zero_steps;
    logic [IDX_W-1:0]         cap_id;
    logic                     cap_dir;
    logic [COUNTER_WIDTH-1:0] cap_exp;
    rsp_err_t                 cap_err;
    logic [STEP_WIDTH-1:0]    remaining;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Offer the grant only while idle and healthy; reset and a pending overflow both suppress it
    always_comb begin
        req_ready = '0;
        if (rst && (state == ST_IDLE) && !cnt_overflow) begin
            req_ready = grant;
        end
        transfer = |(req_valid & req_ready);
    end

    // Select the granted requester's command fields
    always_comb begin
        sel_dir   = 1'b0;
        sel_steps = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dir   = req_dir[i];
                sel_steps = req_steps[i*STEP_WIDTH +: STEP_WIDTH];
            end
        end
    end

    // Range pre-check: reject anything that would take the counter past MAX or below zero
    always_comb begin
        range_bad  = 1'b0;
        up_sum     = SUM_W'(cnt_count) + SUM_W'(sel_steps);
        zero_steps = (sel_steps == '0);
        if (sel_dir) begin
            range_bad = (up_sum > MAX_COUNT);
        end else begin
            range_bad = (SUM_W'(sel_steps) > SUM_W'(cnt_count));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an overflow from the counter always ends in FAULT, via RESP if a command is in flight
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cnt_overflow) begin
                    next_state = ST_FAULT;
                end else if (transfer) begin
                    if (zero_steps || range_bad) begin
                        next_state = ST_RESP;
                    end else begin
                        next_state = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_overflow) begin
                    next_state = ST_RESP;
                end else if (remaining == STEP_WIDTH'(1)) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                next_state = ST_RESP;
            end
            ST_RESP: begin
                if (cnt_overflow || (cap_err == ERR_FAULT)) begin
                    next_state = ST_FAULT;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_FAULT: begin
                next_state = ST_FAULT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted command, count down the steps and note an overflow abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_id    <= '0;
            cap_dir   <= 1'b0;
            cap_exp   <= '0;
            cap_err   <= ERR_OK;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        cap_id    <= grant_idx;
                        cap_dir   <= sel_dir;
                        remaining <= sel_steps;
                        if (range_bad) begin
                            cap_err <= ERR_RANGE;
                            cap_exp <= cnt_count;
                        end else begin
                            cap_err <= ERR_OK;
                            cap_exp <= sel_dir ? (cnt_count + COUNTER_WIDTH'(sel_steps))
                                               : (cnt_count - COUNTER_WIDTH'(sel_steps));
                        end
                    end
                end
                ST_DRIVE: begin
                    remaining <= remaining - STEP_WIDTH'(1);
                    if (cnt_overflow) begin
                        cap_err <= ERR_FAULT;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_overflow) begin
                        cap_err <= ERR_FAULT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from the state; the response verifies the counter against the expected result
    always_comb begin
        cnt_act    = 1'b0;
        cnt_updown = 1'b0;
        rsp_valid  = 1'b0;
        rsp_id     = '0;
        rsp_err    = ERR_OK;
        rsp_count  = '0;
        fault      = 1'b0;
        case (state)
            ST_DRIVE: begin
                cnt_act    = 1'b1;
                cnt_updown = cap_dir;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = cap_id;
                rsp_count = cnt_count;
                if (cap_err == ERR_FAULT) begin
                    rsp_err = ERR_FAULT;
                end else if (cnt_count != cap_exp) begin
                    rsp_err = ERR_MISMATCH;
                end else begin
                    rsp_err = cap_err;
                end
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer with a behavioural up/down counter attached.
module tb_counter_sequencer;
    localparam int COUNTER_WIDTH = 4;
    localparam int STEP_WIDTH    = 4;
    localparam int NUM_REQ       = 2;
    localparam int MAX_COUNT     = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req_dir;
    logic [7:0] req_steps;
    logic       cnt_act;
    logic       cnt_updown;
    logic [3:0] cnt_count;
    logic       cnt_overflow;
    logic       rsp_valid;
    logic [0:0] rsp_id;
    logic [1:0] rsp_err;
    logic [3:0] rsp_count;
    logic       fault;

    logic [3:0] ctr_count;
    logic       ctr_ovf;
    logic       force_ovf;

    int checks    = 0;
    int errors    = 0;
    int act_total = 0;
    int model_count;
    int model_last;

    counter_sequencer #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .STEP_WIDTH    (STEP_WIDTH),
        .NUM_REQ       (NUM_REQ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dir      (req_dir),
        .req_steps    (req_steps),
        .cnt_act      (cnt_act),
        .cnt_updown   (cnt_updown),
        .cnt_count    (cnt_count),
        .cnt_overflow (cnt_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_err      (rsp_err),
        .rsp_count    (rsp_count),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // Counter being sequenced: steps on act, sticky overflow on wrap
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr_count <= 4'd0;
            ctr_ovf   <= 1'b0;
        end else if (cnt_act) begin
            if (cnt_updown) begin
                if (ctr_count == 4'hF) ctr_ovf <= 1'b1;
                ctr_count <= ctr_count + 4'd1;
            end else begin
                if (ctr_count == 4'h0) ctr_ovf <= 1'b1;
                ctr_count <= ctr_count - 4'd1;
            end
        end
    end

    assign cnt_count    = ctr_count;
    assign cnt_overflow = ctr_ovf | force_ovf;

    // Count cycles in which the counter was told to step
    always @(posedge clk) begin
        if (rst && cnt_act) act_total++;
    end

    // Safety net so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] dir,
                                 input logic [3:0] steps0, input logic [3:0] steps1);
        req_valid = valid;
        req_dir   = dir;
        req_steps = {steps1, steps0};
    endtask

    // Reference: next pending requester after the last one granted
    function automatic int modelWinner(input logic [1:0] pending);
        int idx;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (model_last + off) % NUM_REQ;
            if (pending[idx]) return idx;
        end
        return 0;
    endfunction

    // Reference: outcome of one command from plain arithmetic on the counter value
    task automatic modelCommand(input logic dir, input int steps,
                                output int e_err, output int e_count, output int e_lat, output int e_acts);
        int target;
        target = dir ? model_count + steps : model_count - steps;
        if (steps == 0) begin
            e_err = 0; e_lat = 1; e_acts = 0;
        end else if (target < 0 || target > MAX_COUNT) begin
            e_err = 1; e_lat = 1; e_acts = 0;
        end else begin
            e_err = 0; e_lat = steps + 2; e_acts = steps;
            model_count = target;
        end
        e_count = model_count;
    endtask

    // Offer the commands in vmask and serve until every requester has been accepted and answered
    task automatic serveAll(input logic [1:0] vmask, input logic [1:0] dirs,
                            input logic [3:0] s0, input logic [3:0] s1);
        logic [1:0] pending;
        logic [3:0] steps [2];
        int win, lat, act_start, e_err, e_count, e_lat, e_acts;
        steps[0] = s0;
        steps[1] = s1;
        pending  = vmask;
        applyStimulus(pending, dirs, s0, s1);
        while (pending != 2'b00) begin
            #1;
            win = modelWinner(pending);
            checkOutput("req_ready", req_ready, 32'(1) << win);
            modelCommand(dirs[win], int'(steps[win]), e_err, e_count, e_lat, e_acts);
            model_last = win;
            act_start  = act_total;
            @(posedge clk);
            @(negedge clk);
            pending[win] = 1'b0;
            applyStimulus(pending, dirs, s0, s1);
            lat = 1;
            while (rsp_valid !== 1'b1 && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            checkOutput("rsp_latency", lat, e_lat);
            checkOutput("rsp_id", rsp_id, win);
            checkOutput("rsp_err", rsp_err, e_err);
            checkOutput("rsp_count", rsp_count, e_count);
            checkOutput("act_cycles", act_total - act_start, e_acts);
            checkOutput("fault_clear", fault, 0);
            @(negedge clk);
            checkOutput("rsp_pulse", rsp_valid, 0);
        end
    endtask

    initial begin
        int e_count;
        rst       = 1'b0;
        force_ovf = 1'b0;
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        model_count = 0;
        model_last  = NUM_REQ - 1;
        #12;
        checkOutput("reset_ready", req_ready, 0);
        checkOutput("reset_act", cnt_act, 0);
        checkOutput("reset_updown", cnt_updown, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_id", rsp_id, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_rsp_count", rsp_count, 0);
        checkOutput("reset_fault", fault, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single up command from reset");
        serveAll(2'b01, 2'b01, 4'd5, 4'd0);

        $display("[TB] contention between both requesters");
        serveAll(2'b10, 2'b10, 4'd0, 4'd0);
        serveAll(2'b11, 2'b01, 4'd3, 4'd2);
        serveAll(2'b11, 2'b11, 4'd1, 4'd1);

        $display("[TB] upper range boundary");
        serveAll(2'b01, 2'b01, 4'd6, 4'd0);
        serveAll(2'b10, 2'b10, 4'd0, 4'd2);
        serveAll(2'b01, 2'b01, 4'd1, 4'd0);

        $display("[TB] lower range boundary and zero steps");
        serveAll(2'b10, 2'b00, 4'd0, 4'd15);
        serveAll(2'b01, 2'b00, 4'd1, 4'd0);
        serveAll(2'b10, 2'b10, 4'd0, 4'd0);

        $display("[TB] randomized commands");
        for (int i = 0; i < 40; i++) begin
            serveAll(2'($urandom_range(1, 3)), 2'($urandom),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
        end

        $display("[TB] reset in the middle of a command");
        applyStimulus(2'b01, (model_count <= 9) ? 2'b01 : 2'b00, 4'd6, 4'd0);
        #1;
        checkOutput("mid_reset_ready", req_ready, 32'(1) << modelWinner(2'b01));
        @(posedge clk);
        @(negedge clk);
        applyStimulus(2'b11, 2'b11, 4'd2, 4'd3);
        checkOutput("mid_reset_drive", cnt_act, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_ready_low", req_ready, 0);
        checkOutput("mid_reset_act", cnt_act, 0);
        checkOutput("mid_reset_updown", cnt_updown, 0);
        checkOutput("mid_reset_rsp_valid", rsp_valid, 0);
        checkOutput("mid_reset_rsp_err", rsp_err, 0);
        checkOutput("mid_reset_rsp_count", rsp_count, 0);
        checkOutput("mid_reset_rsp_id", rsp_id, 0);
        checkOutput("mid_reset_fault", fault, 0);
        model_count = 0;
        model_last  = NUM_REQ - 1;
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("no_rsp_after_reset", rsp_valid, 0);
        end
        serveAll(2'b11, 2'b11, 4'd2, 4'd3);

        $display("[TB] overflow while driving");
        applyStimulus(2'b01, 2'b01, 4'd6, 4'd0);
        #1;
        checkOutput("ovf_ready", req_ready, 32'(1) << modelWinner(2'b01));
        e_count = model_count + 3;
        @(posedge clk);
        @(negedge clk);
        applyStimulus(2'b00, 2'b00, 4'd0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("ovf_drive", cnt_act, 1);
        force_ovf = 1'b1;
        @(negedge clk);
        checkOutput("ovf_rsp_valid", rsp_valid, 1);
        checkOutput("ovf_rsp_err", rsp_err, 3);
        checkOutput("ovf_rsp_id", rsp_id, 0);
        checkOutput("ovf_rsp_count", rsp_count, e_count);
        checkOutput("ovf_fault_pre", fault, 0);
        applyStimulus(2'b11, 2'b11, 4'd1, 4'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("fault_sticky", fault, 1);
            checkOutput("fault_ready", req_ready, 0);
            checkOutput("fault_rsp_valid", rsp_valid, 0);
            checkOutput("fault_act", cnt_act, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
